alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: requester 0 is the core execute stage, requester 1 is the lookup/parity coprocessor.
- Each request (command, two operands) is accepted on a valid/ready handshake and registered.
- The request is presented to the ALU for one cycle. The ALU result and branch flag are registered and returned on a per-requester valid/ready response channel.
- Round-robin arbitration prevents either requester from starving the other.

---
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0) and the
// lookup/parity coprocessor (requester 1) with round-robin fairness.
module alu_arbiter #(
    parameter int CMD_W  = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CMD_W-1:0]  req0_cmd,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_rslt,
    output logic              rsp0_branch,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CMD_W-1:0]  req1_cmd,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_rslt,
    output logic              rsp1_branch,
    output logic [CMD_W-1:0]  alu_cmd,
    output logic [DATA_W-1:0] alu_inA,
    output logic [DATA_W-1:0] alu_inB,
    input  logic [DATA_W-1:0] alu_rslt,
    input  logic              alu_doBranch,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              r_state;
    logic                r_owner;
    logic                r_prio;
    logic [CMD_W-1:0]    r_alu_cmd;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [DATA_W-1:0]   r_rslt;
    logic                r_branch;
    logic                r_rsp0_valid;
    logic                r_rsp1_valid;
    logic                r_busy;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_rsp_done;

    // The favoured requester wins a tie; the other is granted only if it is alone.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == IDLE && !reset) begin
            if (r_prio == 1'b0) begin
                w_gnt0 = req0_valid;
                w_gnt1 = !req0_valid && req1_valid;
            end else begin
                w_gnt1 = req1_valid;
                w_gnt0 = !req1_valid && req0_valid;
            end
        end
    end

    assign w_rsp_done = r_owner ? (r_rsp1_valid && rsp1_ready)
                                : (r_rsp0_valid && rsp0_ready);

    // The ALU drive registers double as the operand registers: loaded on the
    // handshake and cleared after ISSUE so the ALU sees NOP/0 otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_prio       <= 1'b0;
            r_alu_cmd    <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rslt       <= '0;
            r_branch     <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_owner   <= w_gnt1;
                        r_alu_cmd <= w_gnt1 ? req1_cmd : req0_cmd;
                        r_alu_a   <= w_gnt1 ? req1_a : req0_a;
                        r_alu_b   <= w_gnt1 ? req1_b : req0_b;
                        r_busy    <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_rslt       <= alu_rslt;
                    r_branch     <= alu_doBranch;
                    r_alu_cmd    <= '0;
                    r_alu_a      <= '0;
                    r_alu_b      <= '0;
                    r_rsp0_valid <= !r_owner;
                    r_rsp1_valid <= r_owner;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (w_rsp_done) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_prio       <= !r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_rslt   = r_rslt;
    assign rsp1_rslt   = r_rslt;
    assign rsp0_branch = r_branch;
    assign rsp1_branch = r_branch;
    assign alu_cmd     = r_alu_cmd;
    assign alu_inA     = r_alu_a;
    assign alu_inB     = r_alu_b;
    assign busy        = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter and an ALU stub.
module tb_alu_arbiter;
    localparam int CMD_W  = 5;
    localparam int DATA_W = 8;

    localparam logic [4:0] C_NOP = 5'b00000, C_ADD = 5'b01000, C_SUB = 5'b01001,
                           C_OR  = 5'b01010, C_AND = 5'b01011, C_XOR = 5'b01100,
                           C_MOV = 5'b01101, C_BEQ = 5'b10000, C_BNE = 5'b10001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic [CMD_W-1:0]  req0_cmd = '0, req1_cmd = '0;
    logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_branch, rsp1_branch, busy;
    logic [DATA_W-1:0] rsp0_rslt, rsp1_rslt, alu_inA, alu_inB, alu_rslt;
    logic [CMD_W-1:0]  alu_cmd;
    logic              alu_doBranch;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.CMD_W(CMD_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rslt(rsp0_rslt),
        .rsp0_branch(rsp0_branch),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rslt(rsp1_rslt),
        .rsp1_branch(rsp1_branch),
        .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB),
        .alu_rslt(alu_rslt), .alu_doBranch(alu_doBranch), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stub: returns {branch, result}
    function automatic logic [DATA_W:0] alu_ref(input logic [4:0] c,
                                                input logic [7:0] a, input logic [7:0] b);
        case (c)
            C_NOP:   return '0;
            C_ADD:   return {1'b0, 8'(a + b)};
            C_SUB:   return {1'b0, 8'(a - b)};
            C_OR:    return {1'b0, a | b};
            C_AND:   return {1'b0, a & b};
            C_XOR:   return {1'b0, a ^ b};
            C_MOV:   return {1'b0, b};
            C_BEQ:   return {a == b, 8'h00};
            C_BNE:   return {a != b, 8'h00};
            default: return {c[0], a ^ b ^ {3'b000, c}};
        endcase
    endfunction

    always_comb {alu_doBranch, alu_rslt} = alu_ref(alu_cmd, alu_inA, alu_inB);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction model: one operation in flight, age 0 = on the ALU, age 1 = response out.
    bit         m_active = 0, m_owner = 0, m_prio = 0, m_br = 0, mon_en = 0;
    bit         m_hs0 = 0, m_hs1 = 0;
    int         m_age = 0;
    logic [4:0] m_cmd = '0;
    logic [7:0] m_a = '0, m_b = '0, m_rs = '0;

    function automatic int m_grant();
        if (reset || m_active) return -1;
        if (!m_prio) begin
            if (req0_valid) return 0;
            if (req1_valid) return 1;
        end else begin
            if (req1_valid) return 1;
            if (req0_valid) return 0;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        m_hs0 = 0;
        m_hs1 = 0;
        if (reset) begin
            m_active = 0; m_prio = 0; m_age = 0; m_owner = 0; mon_en = 1;
        end else if (!m_active) begin
            g = m_grant();
            if (g >= 0) begin
                m_active = 1; m_age = 0; m_owner = (g == 1);
                m_cmd = m_owner ? req1_cmd : req0_cmd;
                m_a   = m_owner ? req1_a : req0_a;
                m_b   = m_owner ? req1_b : req0_b;
                {m_br, m_rs} = alu_ref(m_cmd, m_a, m_b);
                if (m_owner) m_hs1 = 1; else m_hs0 = 1;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_active = 0;
            m_prio = !m_owner;
        end
    end

    always @(negedge clk) begin
        bit ev0, ev1, issue;
        if (mon_en) begin
            ev0 = m_active && m_age == 1 && !m_owner;
            ev1 = m_active && m_age == 1 && m_owner;
            issue = m_active && m_age == 0;
            check("req0_ready", 32'(req0_ready), 32'(m_grant() == 0));
            check("req1_ready", 32'(req1_ready), 32'(m_grant() == 1));
            check("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
            check("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
            if (ev0) begin
                check("rsp0_rslt", 32'(rsp0_rslt), 32'(m_rs));
                check("rsp0_branch", 32'(rsp0_branch), 32'(m_br));
            end
            if (ev1) begin
                check("rsp1_rslt", 32'(rsp1_rslt), 32'(m_rs));
                check("rsp1_branch", 32'(rsp1_branch), 32'(m_br));
            end
            check("alu_cmd", 32'(alu_cmd), issue ? 32'(m_cmd) : 32'(0));
            check("alu_inA", 32'(alu_inA), issue ? 32'(m_a) : 32'(0));
            check("alu_inB", 32'(alu_inB), issue ? 32'(m_b) : 32'(0));
            check("busy", 32'(busy), 32'(m_active));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        step();
        step();
        reset = 0;
    endtask

    function automatic logic [4:0] pick_cmd();
        case ($urandom_range(9))
            0: return C_NOP;  1: return C_ADD;  2: return C_SUB;  3: return C_OR;
            4: return C_AND;  5: return C_XOR;  6: return C_MOV;  7: return C_BEQ;
            8: return C_BNE;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        int order[$];
        do_reset();

        // reset values
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_alu_cmd", 32'(alu_cmd), 0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 0);
        check("rst_rsp0_rslt", 32'(rsp0_rslt), 0);
        check("rst_rsp1_rslt", 32'(rsp1_rslt), 0);
        check("rst_rsp1_branch", 32'(rsp1_branch), 0);

        // single ADD on requester 0
        step();
        req0_valid = 1; req0_cmd = C_ADD; req0_a = 8'd5; req0_b = 8'd3; rsp0_ready = 1;
        @(negedge clk);
        check("single_ready", 32'(req0_ready), 1);
        step();
        req0_valid = 0;
        @(negedge clk);
        check("single_issue_cmd", 32'(alu_cmd), 32'(C_ADD));
        check("single_issue_a", 32'(alu_inA), 5);
        step();
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp0_valid), 1);
        check("single_rslt", 32'(rsp0_rslt), 8);
        check("single_branch", 32'(rsp0_branch), 0);
        check("single_cmd_nop", 32'(alu_cmd), 0);
        step();
        @(negedge clk);
        check("single_idle_busy", 32'(busy), 0);

        // fairness: both requesters keep requesting
        do_reset();
        req0_valid = 1; req0_cmd = C_SUB; req0_a = 8'd3;    req0_b = 8'd5;
        req1_valid = 1; req1_cmd = C_OR;  req1_a = 8'hF0;   req1_b = 8'h0F;
        rsp0_ready = 1; rsp1_ready = 1;
        n = 0;
        while (order.size() < 4 && n < 40) begin
            @(negedge clk);
            if (req0_ready) order.push_back(0);
            if (req1_ready) order.push_back(1);
            if (rsp0_valid) check("fair_rsp0_rslt", 32'(rsp0_rslt), 32'h0FE);
            if (rsp1_valid) check("fair_rsp1_rslt", 32'(rsp1_rslt), 32'h0FF);
            step();
            n++;
        end
        check("fair_grants", 32'(order.size()), 4);
        for (int i = 0; i < order.size() && i < 4; i++)
            check("fair_order", 32'(order[i]), 32'(i % 2));
        req0_valid = 0; req1_valid = 0;
        repeat (4) step();

        // back-pressure on requester 1
        do_reset();
        req1_valid = 1; req1_cmd = C_MOV; req1_a = 8'h00; req1_b = 8'h5A; rsp1_ready = 0;
        n = 0;
        do begin @(negedge clk); n++; if (!req1_ready) step(); end while (!req1_ready && n < 5);
        check("bp_grant", 32'(req1_ready), 1);
        step();
        req1_valid = 0;
        req0_valid = 1; req0_cmd = C_ADD; req0_a = 8'd1; req0_b = 8'd2; rsp0_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; if (!rsp1_valid) step(); end while (!rsp1_valid && n < 5);
        check("bp_rsp_seen", 32'(rsp1_valid), 1);
        step();
        repeat (4) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp1_valid), 1);
            check("bp_hold_rslt", 32'(rsp1_rslt), 32'h05A);
            check("bp_block_req0", 32'(req0_ready), 0);
            step();
        end
        rsp1_ready = 1;
        step();
        @(negedge clk);
        check("bp_req0_served", 32'(req0_ready), 1);
        step();
        req0_valid = 0;
        repeat (3) step();

        // withdrawal during RESP of requester 1
        do_reset();
        req1_valid = 1; req1_cmd = C_OR; req1_a = 8'h11; req1_b = 8'h22; rsp1_ready = 0;
        step();
        req1_valid = 0;
        step();
        @(negedge clk);
        check("wd_rsp_valid", 32'(rsp1_valid), 1);
        step();
        req0_valid = 1; req0_cmd = C_ADD;
        @(negedge clk);
        check("wd_pulse_ready", 32'(req0_ready), 0);
        step();
        req0_valid = 0; rsp1_ready = 1;
        step();
        @(negedge clk);
        check("wd_idle_busy", 32'(busy), 0);
        check("wd_no_grant", 32'(req0_ready), 0);
        step();
        @(negedge clk);
        check("wd_quiet_cmd", 32'(alu_cmd), 0);
        step();

        // reset in the middle of an ADD
        do_reset();
        req0_valid = 1; req0_cmd = C_ADD; req0_a = 8'd7; req0_b = 8'd9; rsp0_ready = 1;
        step();
        req0_valid = 0; reset = 1;
        @(negedge clk);
        check("rmid_issue_cmd", 32'(alu_cmd), 32'(C_ADD));
        step();
        reset = 0;
        @(negedge clk);
        check("rmid_rsp0_valid", 32'(rsp0_valid), 0);
        check("rmid_busy", 32'(busy), 0);
        check("rmid_cmd", 32'(alu_cmd), 0);
        req0_valid = 1; req1_valid = 1; req1_cmd = C_SUB; req1_a = 8'd9; req1_b = 8'd4;
        rsp1_ready = 1;
        #1;
        check("rmid_prio0", 32'(req0_ready), 1);
        check("rmid_prio0_r1", 32'(req1_ready), 0);
        req0_valid = 0;
        #1;
        check("rmid_req1_ready", 32'(req1_ready), 1);
        step();
        req1_valid = 0;
        step();
        @(negedge clk);
        check("rmid_req1_rsp", 32'(rsp1_valid), 1);
        check("rmid_req1_rslt", 32'(rsp1_rslt), 5);
        step();

        // idle quiet
        req0_valid = 0; req1_valid = 0;
        repeat (2) step();
        repeat (10) begin
            @(negedge clk);
            check("quiet_cmd", 32'(alu_cmd), 0);
            check("quiet_ab", 32'({alu_inA, alu_inB}), 0);
            check("quiet_out", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 0);
            step();
        end

        // randomized traffic
        repeat (3000) begin
            if (m_hs0) req0_valid = 0;
            if (m_hs1) req1_valid = 0;
            if (req0_valid && $urandom_range(7) == 0) req0_valid = 0;
            else if (!req0_valid && $urandom_range(1) == 1) begin
                req0_valid = 1; req0_cmd = pick_cmd(); req0_a = 8'($urandom);
                req0_b = ($urandom_range(3) == 0) ? req0_a : 8'($urandom);
            end
            if (req1_valid && $urandom_range(7) == 0) req1_valid = 0;
            else if (!req1_valid && $urandom_range(1) == 1) begin
                req1_valid = 1; req1_cmd = pick_cmd(); req1_a = 8'($urandom);
                req1_b = ($urandom_range(3) == 0) ? req1_a : 8'($urandom);
            end
            rsp0_ready = 1'($urandom_range(1));
            rsp1_ready = 1'($urandom_range(1));
            reset = ($urandom_range(99) == 0);
            step();
        end
        reset = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
